uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio.sv | 110 +++++++++++
 tb/tb_uart_tx_mmio.sv | 124 ++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: store-bus byte FIFO feeding an 8N1 serial transmitter with a polled status word.
// Define UART_SIM_PRINT_EN to echo each dequeued byte with $write in simulation.
module uart_tx_mmio #(
  parameter int          CLK_DIV     = 868,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] DATA_ADDR   = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h1000_0004
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic [31:0] addra,
  input  logic [31:0] dina,
  input  logic        wea,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] bit_idx, bit_d;
  logic [7:0] shift, shift_d;
  logic tx_d, overflow, empty, full, tx_active, tick, push_req, push, pop, clr, unused;
  assign empty = count == '0;
  assign full = count == DEPTH;
  assign tick = cnt == '0;
  assign push_req = wea && addra == DATA_ADDR;
  assign clr = wea && addra == STATUS_ADDR && dina[3];
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push = push_req && (!full || pop);
  assign unused = ^{dina[31:8], dina[2:0]};
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      bit_idx <= bit_d;
      shift <= shift_d;
      tx <= tx_d;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow <= (push_req && full && !pop) || (overflow && !clr);
    end
  end
  always_ff @(posedge clka) begin
    if (push) mem[wr_ptr] <= dina[7:0];
  end
  always_comb begin
    state_d = state;
    cnt_d = (state == IDLE) ? cnt : (tick ? CNT_LOAD : cnt - 1'b1);
    bit_d = bit_idx;
    shift_d = shift;
    tx_d = tx;
    pop = 1'b0;
    case (state)
      IDLE: pop = !empty;
      START: if (tick) begin
        state_d = DATA;
        tx_d = shift[0];
        bit_d = '0;
      end
      DATA: if (tick) begin
        state_d = (bit_idx == 3'd7) ? STOP : DATA;
        tx_d = (bit_idx == 3'd7) ? 1'b1 : shift[1];
        bit_d = bit_idx + 1'b1;
        shift_d = shift >> 1;
      end
      STOP: if (tick) begin
        pop = !empty;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // dequeue from IDLE or straight out of STOP: load the byte and drive the start bit
    if (pop) begin
      state_d = START;
      shift_d = mem[rd_ptr];
      tx_d = 1'b0;
      cnt_d = CNT_LOAD;
    end
  end
  always_comb begin
    tx_active = state != IDLE;
    busy = tx_active | ~empty;
    rd_data = (addra == STATUS_ADDR) ? {28'b0, overflow, empty, full, tx_active} : '0;
  end
`ifdef UART_SIM_PRINT_EN
  always_ff @(posedge clka) begin
    if (rst_n && pop) $write("%c", mem[rd_ptr]);
  end
`else
`endif
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=8.
module tb_uart_tx_mmio;
  localparam logic [31:0] DA = 32'h1000_0000;
  localparam logic [31:0] SA = 32'h1000_0004;
  logic clka = 1'b0, rst_n = 1'b0, wea = 1'b0, tx, busy;
  logic [31:0] addra = '0, dina = '0, rd_data;
  int checks = 0, errors = 0;
  uart_tx_mmio #(.CLK_DIV(4), .FIFO_DEPTH(8)) dut (
    .clka(clka), .rst_n(rst_n), .addra(addra), .dina(dina), .wea(wea),
    .rd_data(rd_data), .tx(tx), .busy(busy)
  );
  always #5 clka = ~clka;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // expected line level at cycle offset off (0..39) of a frame carrying b, 4 clocks per bit
  function automatic logic frame_bit(input logic [7:0] b, input int off);
    return off < 4 ? 1'b0 : (off < 36 ? b[(off - 4) / 4] : 1'b1);
  endfunction
  task automatic step();
    @(posedge clka);
    #1;
  endtask
  initial begin
    logic seen0;
    logic [7:0] exp_b;
    step();
    step();
    rst_n = 1'b1;
    addra = SA;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_status", rd_data, 32'h4);
    wea = 1'b1;
    addra = DA;
    dina = 32'hFFFF_FF55;
    step();
    wea = 1'b0;
    addra = SA;
    #1;
    chk("t2_tx_before_pop", tx, 1);
    chk("t2_busy_queued", busy, 1);
    chk("t2_status_queued", rd_data, 32'h0);
    for (int k = 1; k <= 41; k++) begin
      step();
      if (k <= 40) chk("t2_tx", tx, frame_bit(8'h55, k - 1));
      if (k == 40) chk("t2_busy_end", busy, 1);
    end
    chk("t2_busy_idle", busy, 0);
    chk("t2_status_idle", rd_data, 32'h4);
    for (int k = 0; k <= 401; k++) begin
      wea = (k <= 9) || k == 15 || k == 20 || k == 41;
      addra = (k <= 9 || k == 41) ? DA : SA;
      dina = k <= 9 ? 32'(k + 1) : (k == 41 ? 32'h0B : (k == 20 ? 32'h8 : 32'h0));
      step();
      wea = 1'b0;
      addra = SA;
      #1;
      if (k >= 1 && k <= 400) begin
        exp_b = ((k - 1) / 40 < 9) ? 8'((k - 1) / 40 + 1) : 8'h0B;
        chk("t3_tx", tx, frame_bit(exp_b, (k - 1) % 40));
      end
      if (k == 8) chk("t3_full", rd_data, 32'h3);
      if (k == 9) chk("t3_overflow", rd_data, 32'hB);
      if (k == 15) chk("t3_clear0_keeps", rd_data, 32'hB);
      if (k == 20) chk("t3_clear8", rd_data, 32'h3);
      if (k == 41) chk("t3_push_pop_full", rd_data, 32'h3);
      if (k == 400) chk("t3_busy_last", busy, 1);
      if (k == 401) begin
        chk("t3_busy_idle", busy, 0);
        chk("t3_status_idle", rd_data, 32'h4);
      end
    end
    for (int k = 0; k <= 10; k++) begin
      wea = k <= 2;
      addra = k <= 2 ? DA : SA;
      dina = k == 0 ? 32'hA5 : (k == 1 ? 32'h3C : 32'hFF);
      step();
    end
    wea = 1'b0;
    addra = SA;
    #1;
    chk("t5_mid_frame", tx, 0);
    rst_n = 1'b0;
    step();
    chk("t5_rst_tx", tx, 1);
    chk("t5_rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("t5_rst_status", rd_data, 32'h4);
    seen0 = 1'b0;
    repeat (100) begin
      step();
      if (tx !== 1'b1) seen0 = 1'b1;
    end
    chk("t5_quiet", seen0, 0);
    wea = 1'b1;
    addra = 32'h1000_0008;
    dina = 32'h41;
    step();
    wea = 1'b0;
    chk("t6_other_rd", rd_data, 32'h0);
    chk("t6_busy", busy, 0);
    addra = DA;
    #1;
    chk("t6_data_rd", rd_data, 32'h0);
    addra = SA;
    #1;
    chk("t6_status", rd_data, 32'h4);
    seen0 = 1'b0;
    repeat (10) begin
      step();
      if (tx !== 1'b1) seen0 = 1'b1;
    end
    chk("t6_tx_idle", seen0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
